// File: rtl/mdu_pkg.sv
// Shared op-code and latency definitions for the multiply/divide unit.
// The decoder and hazard unit import the same names.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MADD  = 3'b100;
  localparam logic [2:0] MDU_MADDU = 3'b101;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    IDLE,
    RUN
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generation for the MDU.
// Accumulate ops are built only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [63:0] acc,
  output logic [63:0] result,
  output logic        valid,
  output logic        is_div,
  output logic        div_zero
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic               sdiv, a_neg, b_neg;
  logic        [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

  assign sprod = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
  assign uprod = {32'd0, opa} * {32'd0, opb};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
  assign sdiv    = (op == MDU_DIV);
  assign a_neg   = sdiv & opa[31];
  assign b_neg   = sdiv & opb[31];
  assign a_mag   = a_neg ? -opa : opa;
  assign b_mag   = b_neg ? -opb : opb;
  assign divisor = (opb == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;

  // NOTE: every output gets a default before the case, otherwise the
  // op codes that do not assign them would infer latches.
  always_comb begin
    result   = '0;
    valid    = 1'b0;
    is_div   = 1'b0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  begin result = $unsigned(sprod); valid = 1'b1; end
      MDU_MULTU: begin result = uprod;            valid = 1'b1; end
      MDU_DIV, MDU_DIVU: begin
        result   = {rem, quot};
        valid    = 1'b1;
        is_div   = 1'b1;
        div_zero = (opb == 32'd0);
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin result = acc + $unsigned(sprod); valid = 1'b1; end
      MDU_MADDU: begin result = acc + uprod;            valid = 1'b1; end
`endif
      default: ;
    endcase
  end

`ifndef MDU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^acc;
`endif

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and busy flag.
// Optional MADD/MADDU support under MDU_MADD_EN.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [63:0]      pend, pend_d;
  logic             skip, skip_d;
  logic [31:0]      hi_d, lo_d;
  logic [63:0]      result;
  logic             valid, is_div, div_zero;

  mdu_arith u_arith (
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .acc      ({hi, lo}),
    .result   (result),
    .valid    (valid),
    .is_div   (is_div),
    .div_zero (div_zero)
  );

  assign state = (cnt != '0) ? RUN : IDLE;
  assign busy  = (state == RUN);

  always_comb begin
    cnt_d  = cnt;
    pend_d = pend;
    skip_d = skip;
    hi_d   = hi;
    lo_d   = lo;
    case (state)
      IDLE: begin
        if (start && valid) begin
          pend_d = result;
          skip_d = div_zero;
          cnt_d  = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else begin
          if (mthi) hi_d = opa;
          if (mtlo) lo_d = opa;
        end
      end
      RUN: begin
        cnt_d = cnt - CNT_W'(1);
        // Divide by zero leaves HI/LO untouched at commit.
        if (cnt == CNT_W'(1) && !skip) {hi_d, lo_d} = pend;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values computed by the combinational block.
  // NOTE: the pending result is reset as well, so an aborted operation
  // leaves no stale value that could ever be committed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      pend <= '0;
      skip <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      cnt  <= cnt_d;
      pend <= pend_d;
      skip <= skip_d;
      hi   <= hi_d;
      lo   <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO and busy length are queued at
// issue and compared when busy drops.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .opa   (opa),
    .opb   (opb),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues the op and returns at the first negedge
  // with busy low, so consecutive calls are back-to-back.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int cyc, input bit poke);
    exp_t e;
    int   n;
    exp_q.push_back('{tag, eh, el, cyc});
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":old"}, {hi, lo}, {m_hi, m_lo});
    n = 0;
    while (busy && n < 200) begin
      if (poke && n == 1) begin
        start = 1'b1; op = MDU_MULT; opa = 32'h0000DEAD; opb = 32'd2; mthi = 1'b1;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0;
    e = exp_q.pop_front();
    check({e.tag, ":cycles"}, 64'(n), 64'(e.cycles));
    check({e.tag, ":hilo"}, {hi, lo}, {e.hi, e.lo});
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] v);
    mthi = h; mtlo = l; opa = v;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    check("mt", {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    do_op("mult",    MDU_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1'b0);
    do_op("multu",   MDU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0);
    do_op("divu",    MDU_DIVU,  32'd7,        32'd2, 32'd1,        32'd3,        10, 1'b0);
    do_op("div_neg", MDU_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    do_op("div0",    MDU_DIV,   32'd5,        32'd0, 32'h11,       32'h22,       10, 1'b0);
    do_op("div_ovf", MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 1'b0);
    do_op("ignore",  MDU_MULT,  32'd3,        32'd4, 32'd0,        32'd12,       5, 1'b1);
    do_op("undef",   3'b110,    32'd9,        32'd9, 32'd0,        32'd12,       0, 1'b0);
    mt(1'b1, 1'b1, 32'h77);

    // Reset in the middle of a divide discards the in-flight result.
    start = 1'b1; op = MDU_DIV; opa = 32'd100; opb = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("rst_after_busy", 64'(busy), 64'd0);
    mt(1'b0, 1'b1, 32'h5);

    mt(1'b1, 1'b0, 32'h1);
    mt(1'b0, 1'b1, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    do_op("maddu", MDU_MADDU, 32'd1,        32'd1, 32'd2, 32'd0,        5, 1'b0);
    do_op("madd",  MDU_MADD,  32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 5, 1'b0);
`else
    do_op("maddu_off", 3'b101, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 0, 1'b0);
    do_op("madd_off",  3'b100, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
